// File: rtl/cpu_trace_parser_pkg.sv
// Shared definitions for the CPU write-trace parser: FSM states, ASCII tokens,
// line formats, error bit positions and small arithmetic helpers.
package cpu_trace_parser_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CARET, ST_TIME, ST_PC, ST_COLON, ST_REG_S, ST_REG,
        ST_MEM_S, ST_ADDR, ST_SP, ST_LT, ST_EQ, ST_DATA, ST_DONE
    } state_t;

    localparam logic [7:0] ASC_CARET  = 8'h5E;
    localparam logic [7:0] ASC_AT     = 8'h40;
    localparam logic [7:0] ASC_COLON  = 8'h3A;
    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_LT     = 8'h3C;
    localparam logic [7:0] ASC_EQ     = 8'h3D;
    localparam logic [7:0] ASC_HASH   = 8'h23;
    localparam logic [7:0] ASC_SPACE  = 8'h20;

    localparam logic [1:0] FMT_NONE = 2'd0;
    localparam logic [1:0] FMT_REG  = 2'd1;
    localparam logic [1:0] FMT_MEM  = 2'd2;

    localparam int ERR_TIME_ODD = 0;
    localparam int ERR_PC       = 1;
    localparam int ERR_ADDR     = 2;
    localparam int ERR_REG      = 3;

    function automatic logic [31:0] dec_step(input logic [31:0] acc, input logic [3:0] d);
        return acc * 32'd10 + {28'd0, d};
    endfunction

    // Wrapping subtraction turns the two-sided bound into one unsigned compare.
    function automatic logic in_range(input logic [31:0] v, input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v - lo) <= (hi - lo);
    endfunction

endpackage

// File: rtl/cpu_trace_parser_char_class.sv
// Combinational ASCII classifier: decimal / hex / space flags and hex nibble value.
module trace_char_class
    import cpu_trace_parser_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_dec_o,
    output logic       is_hex_o,
    output logic       is_space_o,
    output logic [3:0] nibble_o
);

    logic is_lc;
    logic is_uc;

    always_comb begin
        is_dec_o   = (char_i >= 8'h30) && (char_i <= 8'h39);
        is_lc      = (char_i >= 8'h61) && (char_i <= 8'h66);
        is_uc      = (char_i >= 8'h41) && (char_i <= 8'h46);
        is_hex_o   = is_dec_o || is_lc || is_uc;
        is_space_o = (char_i == ASC_SPACE);
        nibble_o   = 4'd0;
        if (is_dec_o) begin
            nibble_o = char_i[3:0];
        end else if (is_lc || is_uc) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15.
            nibble_o = char_i[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/cpu_trace_parser.sv
// Character-serial parser for register/memory write trace lines; extracts the
// fields of each complete line and flags semantic errors on a one-cycle valid.
module cpu_trace_parser
    import cpu_trace_parser_pkg::*;
#(
    parameter int          MAX_TIME_DIG = 4,
    parameter int          TIME_W       = 14,
    parameter int          MAX_REG_DIG  = 4,
    parameter int          REG_W        = 14,
    parameter int          HEX_DIG      = 8,
    parameter logic [31:0] PC_LO        = 32'h3000,
    parameter logic [31:0] PC_HI        = 32'h4fff,
    parameter logic [31:0] AD_LO        = 32'h0,
    parameter logic [31:0] AD_HI        = 32'h2fff
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             char,
    output logic                   valid,
    output logic [1:0]             format_type,
    output logic [TIME_W-1:0]      time_val,
    output logic [4*HEX_DIG-1:0]   pc_val,
    output logic [4*HEX_DIG-1:0]   dest_val,
    output logic [4*HEX_DIG-1:0]   data_val,
    output logic [3:0]             err_code
);

    localparam int AW = 4 * HEX_DIG;

    logic       is_dec, is_hex, is_space;
    logic [3:0] nib;

    trace_char_class u_class (
        .char_i     (char),
        .is_dec_o   (is_dec),
        .is_hex_o   (is_hex),
        .is_space_o (is_space),
        .nibble_o   (nib)
    );

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic              is_mem_q;
    logic [TIME_W-1:0] time_acc_q;
    logic [REG_W-1:0]  reg_acc_q;
    logic [AW-1:0]     pc_acc_q, addr_acc_q, data_acc_q;

    logic              valid_q;
    logic [1:0]        fmt_q;
    logic [TIME_W-1:0] time_q;
    logic [AW-1:0]     pc_q, dest_q, data_q;
    logic [3:0]        err_q;

    logic [31:0]       time_dec, reg_dec;
    logic [3:0]        err_d;
    logic              hex_full;

    always_comb begin
        time_dec = dec_step(32'(time_acc_q), nib);
        reg_dec  = dec_step(32'(reg_acc_q), nib);
        hex_full = (cnt_q == 8'(HEX_DIG));
        err_d                = 4'd0;
        err_d[ERR_TIME_ODD]  = time_acc_q[0];
        err_d[ERR_PC]        = !in_range(32'(pc_acc_q), PC_LO, PC_HI) || (pc_acc_q[1:0] != 2'b00);
        err_d[ERR_ADDR]      = is_mem_q &&
                               (!in_range(32'(addr_acc_q), AD_LO, AD_HI) || (addr_acc_q[1:0] != 2'b00));
        err_d[ERR_REG]       = !is_mem_q && (reg_acc_q > REG_W'(31));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_mem_q   <= 1'b0;
            time_acc_q <= '0;
            reg_acc_q  <= '0;
            pc_acc_q   <= '0;
            addr_acc_q <= '0;
            data_acc_q <= '0;
            valid_q    <= 1'b0;
            fmt_q      <= FMT_NONE;
            time_q     <= '0;
            pc_q       <= '0;
            dest_q     <= '0;
            data_q     <= '0;
            err_q      <= '0;
        end else begin
            valid_q <= 1'b0;
            fmt_q   <= FMT_NONE;
            if (char == ASC_CARET) begin
                // A caret always starts a fresh line, wherever we were.
                state_q    <= ST_CARET;
                cnt_q      <= '0;
                time_acc_q <= '0;
                reg_acc_q  <= '0;
                pc_acc_q   <= '0;
                addr_acc_q <= '0;
                data_acc_q <= '0;
            end else begin
                state_q <= ST_IDLE;
                case (state_q)
                    ST_CARET, ST_TIME: begin
                        if (is_dec && (state_q == ST_CARET || cnt_q < 8'(MAX_TIME_DIG))) begin
                            state_q    <= ST_TIME;
                            time_acc_q <= time_dec[TIME_W-1:0];
                            cnt_q      <= cnt_q + 8'd1;
                        end else if (state_q == ST_TIME && char == ASC_AT) begin
                            state_q <= ST_PC;
                            cnt_q   <= '0;
                        end
                    end
                    ST_PC: begin
                        if (is_hex && cnt_q < 8'(HEX_DIG)) begin
                            state_q  <= ST_PC;
                            pc_acc_q <= {pc_acc_q[AW-5:0], nib};
                            cnt_q    <= cnt_q + 8'd1;
                        end else if (char == ASC_COLON && hex_full) begin
                            state_q <= ST_COLON;
                        end
                    end
                    ST_COLON: begin
                        if (is_space) begin
                            state_q <= ST_COLON;
                        end else if (char == ASC_DOLLAR) begin
                            state_q  <= ST_REG_S;
                            is_mem_q <= 1'b0;
                            cnt_q    <= '0;
                        end else if (char == ASC_STAR) begin
                            state_q  <= ST_MEM_S;
                            is_mem_q <= 1'b1;
                            cnt_q    <= '0;
                        end
                    end
                    ST_REG_S, ST_REG: begin
                        if (is_dec && (state_q == ST_REG_S || cnt_q < 8'(MAX_REG_DIG))) begin
                            state_q   <= ST_REG;
                            reg_acc_q <= reg_dec[REG_W-1:0];
                            cnt_q     <= cnt_q + 8'd1;
                        end else if (state_q == ST_REG && is_space) begin
                            state_q <= ST_SP;
                        end else if (state_q == ST_REG && char == ASC_LT) begin
                            state_q <= ST_LT;
                        end
                    end
                    ST_MEM_S, ST_ADDR: begin
                        if (is_hex && cnt_q < 8'(HEX_DIG)) begin
                            state_q    <= ST_ADDR;
                            addr_acc_q <= {addr_acc_q[AW-5:0], nib};
                            cnt_q      <= cnt_q + 8'd1;
                        end else if (state_q == ST_ADDR && hex_full && is_space) begin
                            state_q <= ST_SP;
                        end else if (state_q == ST_ADDR && hex_full && char == ASC_LT) begin
                            state_q <= ST_LT;
                        end
                    end
                    ST_SP: begin
                        if (is_space)           state_q <= ST_SP;
                        else if (char == ASC_LT) state_q <= ST_LT;
                    end
                    ST_LT: begin
                        if (char == ASC_EQ) begin
                            state_q <= ST_EQ;
                            cnt_q   <= '0;
                        end
                    end
                    ST_EQ, ST_DATA: begin
                        if (is_hex && (state_q == ST_EQ || cnt_q < 8'(HEX_DIG))) begin
                            state_q    <= ST_DATA;
                            data_acc_q <= {data_acc_q[AW-5:0], nib};
                            cnt_q      <= cnt_q + 8'd1;
                        end else if (state_q == ST_EQ && is_space) begin
                            state_q <= ST_EQ;
                        end else if (state_q == ST_DATA && hex_full && char == ASC_HASH) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                            fmt_q   <= is_mem_q ? FMT_MEM : FMT_REG;
                            time_q  <= time_acc_q;
                            pc_q    <= pc_acc_q;
                            dest_q  <= is_mem_q ? addr_acc_q : AW'(reg_acc_q);
                            data_q  <= data_acc_q;
                            err_q   <= err_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign valid       = valid_q;
    assign format_type = fmt_q;
    assign time_val    = time_q;
    assign pc_val      = pc_q;
    assign dest_val    = dest_q;
    assign data_val    = data_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Scoreboard bench for cpu_trace_parser: directed and random trace lines.
module tb_cpu_trace_parser;

    localparam int TIME_W = 14;
    localparam int AW     = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        ch = 8'h20;
    logic              valid;
    logic [1:0]        format_type;
    logic [TIME_W-1:0] time_val;
    logic [AW-1:0]     pc_val, dest_val, data_val;
    logic [3:0]        err_code;

    always #5 clk = ~clk;

    cpu_trace_parser dut (
        .clk         (clk),
        .reset       (reset),
        .char        (ch),
        .valid       (valid),
        .format_type (format_type),
        .time_val    (time_val),
        .pc_val      (pc_val),
        .dest_val    (dest_val),
        .data_val    (data_val),
        .err_code    (err_code)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [13:0] t;
        logic [31:0] pc;
        logic [31:0] dest;
        logic [31:0] data;
        logic [3:0]  err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_err(input bit mem, input int unsigned t,
                                             input logic [31:0] pc, input logic [31:0] dest);
        logic [3:0] r;
        r[0] = t[0];
        r[1] = (pc < 32'h3000) || (pc > 32'h4fff) || (pc[1:0] != 2'b00);
        r[2] = mem && ((dest > 32'h2fff) || (dest[1:0] != 2'b00));
        r[3] = !mem && (dest > 32'd31);
        return r;
    endfunction

    task automatic push(input logic [1:0] f, input int unsigned t, input logic [31:0] pc,
                        input logic [31:0] dest, input logic [31:0] data, input logic [3:0] err);
        exp_t x;
        x.fmt = f; x.t = t[13:0]; x.pc = pc; x.dest = dest; x.data = data; x.err = err;
        exp_q.push_back(x);
    endtask

    task automatic send_char(input logic [7:0] c);
        ch = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("fmt",  format_type, e.fmt);
                    check_val("time", time_val,    e.t);
                    check_val("pc",   pc_val,      e.pc);
                    check_val("dest", dest_val,    e.dest);
                    check_val("data", data_val,    e.data);
                    check_val("err",  err_code,    e.err);
                end
            end else begin
                check_val("fmt_idle", format_type, 2'd0);
            end
        end
    end

    initial begin
        bit          mem;
        int unsigned t;
        logic [31:0] pc, dest, data;
        string       s;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", valid, 1'b0);
        check_val("rst_fmt",   format_type, 2'd0);
        check_val("rst_time",  time_val, 14'd0);
        check_val("rst_pc",    pc_val, 32'd0);
        check_val("rst_dest",  dest_val, 32'd0);
        check_val("rst_data",  data_val, 32'd0);
        check_val("rst_err",   err_code, 4'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        push(2'd1, 10, 32'h3004, 32'd5, 32'h0000abcd, 4'b0000);
        send_str("^10@00003004: $5 <= 0000abcd#");
        send_str("  ");
        push(2'd2, 7, 32'h2ffc, 32'h10, 32'hdeadbeef, 4'b0011);
        send_str("^7@00002ffc:*00000010<=DEADBEEF#");
        send_str("^12345@00003000: $1 <= 00000001#");
        send_str("^2@0000300: $1 <= 00000001#");
        send_str("^2@00003000: $1 < = 00000001#");
        push(2'd1, 2, 32'h3000, 32'd40, 32'h0, 4'b1000);
        send_str("^2@00003000: $40 <= 00000000#");
        push(2'd2, 2, 32'h3000, 32'h3000, 32'h0, 4'b0100);
        send_str("^2@00003000: *00003000 <= 00000000#");
        push(2'd1, 3, 32'h3002, 32'd32, 32'h0000ffff, 4'b1011);
        send_str("^3@00003002: $32 <= 0000FFFF#");
        push(2'd1, 2, 32'h3000, 32'd1, 32'h1, 4'b0000);
        send_str("^1@00^2@00003000: $1 <= 00000001#");

        send_str("^2@0000");
        reset = 1'b1;
        ch = 8'h20;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_str("3000: $1 <= 00000001#");

        push(2'd1, 10, 32'h3004, 32'd5, 32'h0000abcd, 4'b0000);
        push(2'd2, 4, 32'h3008, 32'h100, 32'h12345678, 4'b0000);
        send_str("^10@00003004: $5 <= 0000abcd#^4@00003008: *00000100 <= 12345678#");

        for (int n = 0; n < 8; n++) begin
            mem  = 1'($urandom_range(0, 1));
            t    = $urandom_range(0, 9999);
            pc   = $urandom_range(32'h2ff0, 32'h5010);
            dest = mem ? $urandom_range(0, 32'h3010) : $urandom_range(0, 40);
            data = $urandom;
            if (mem) s = $sformatf("^%0d@%08x: *%08x <= %08x#", t, pc, dest, data);
            else     s = $sformatf("^%0d@%08x: $%0d <= %08x#", t, pc, dest, data);
            push(mem ? 2'd2 : 2'd1, t, pc, dest, data, model_err(mem, t, pc, dest));
            send_str(s);
        end

        repeat (5) send_char(8'h20);
        check_val("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
